// File: rtl/lpc_encoder_pp_if.sv
// Stream bundle for lpc_encoder_pp: input beat handshake plus the coded-block output handshake.
// master = upstream/downstream environment, slave = the encoder.
interface lpc_encoder_pp_if #(
    parameter int unsigned SYM_W         = 8,
    parameter int unsigned SYMS_PER_BEAT = 2,
    parameter int unsigned BEATS         = 4
);
    localparam int unsigned N      = SYMS_PER_BEAT * BEATS;
    localparam int unsigned IN_W   = SYMS_PER_BEAT * SYM_W;
    localparam int unsigned CODE_W = N * SYM_W + N + SYM_W;
    localparam int unsigned CW     = $clog2(BEATS + 1);

    logic [IN_W-1:0]   IN_SOURCE;
    logic              IN_VALID;
    logic              READY;
    logic              T_LAST;
    logic              SAMPLE_LAST;
    logic              FLUSH;
    logic              OUT_VALID;
    logic [CODE_W-1:0] OUT_CODED;
    logic [BEATS-1:0]  OUT_LAST;
    logic [CW-1:0]     OUT_USER;
    logic              T_READY;

    modport master (
        output IN_SOURCE, IN_VALID, T_LAST, SAMPLE_LAST, FLUSH, T_READY,
        input  READY, OUT_VALID, OUT_CODED, OUT_LAST, OUT_USER
    );

    modport slave (
        input  IN_SOURCE, IN_VALID, T_LAST, SAMPLE_LAST, FLUSH, T_READY,
        output READY, OUT_VALID, OUT_CODED, OUT_LAST, OUT_USER
    );
endinterface

// File: rtl/lpc_encoder_pp.sv
// 2D-parity block encoder: assembles BEATS beats into a block, adds row/column parity,
// and hands the block to a separate output register so input can continue under backpressure.
module lpc_encoder_pp #(
    parameter int unsigned SYM_W         = 8,
    parameter int unsigned SYMS_PER_BEAT = 2,
    parameter int unsigned BEATS         = 4,
    parameter bit          ODD           = 1'b0
) (
    input logic               ACLK,
    input logic               ARESET,
    lpc_encoder_pp_if.slave   bus
);
    localparam int unsigned N      = SYMS_PER_BEAT * BEATS;
    localparam int unsigned IN_W   = SYMS_PER_BEAT * SYM_W;
    localparam int unsigned DATA_W = N * SYM_W;
    localparam int unsigned CODE_W = DATA_W + N + SYM_W;
    localparam int unsigned CW     = $clog2(BEATS + 1);

    // Assembly buffer; parities are kept as even parity, ODD is applied on transfer.
    logic [DATA_W-1:0] data_q, data_d;
    logic [N-1:0]      rowp_q, rowp_d;
    logic [SYM_W-1:0]  colp_q, colp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BEATS-1:0]  last_q, last_d;
    logic              held_q, held_d;
    logic              ready_q, ready_d;

    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] out_coded_q, out_coded_d;
    logic [BEATS-1:0]  out_last_q, out_last_d;
    logic [CW-1:0]     out_user_q, out_user_d;

    logic [DATA_W-1:0]        data_m;
    logic [N-1:0]             rowp_m;
    logic [SYM_W-1:0]         colp_m;
    logic [BEATS-1:0]         last_m;
    logic [SYMS_PER_BEAT-1:0] beat_rowp;
    logic [SYM_W-1:0]         beat_colp;

    logic accept, complete, out_fire, out_free;

    assign accept   = bus.IN_VALID & ready_q;
    assign complete = accept & (bus.T_LAST | (cnt_q == CW'(BEATS - 1)));
    assign out_fire = out_valid_q & bus.T_READY;
    assign out_free = ~out_valid_q | bus.T_READY;

    // Buffer contents with the current beat merged into its slots.
    always_comb begin
        beat_rowp = '0;
        beat_colp = '0;
        for (int s = 0; s < SYMS_PER_BEAT; s++) begin
            beat_rowp[s] = ^bus.IN_SOURCE[s*SYM_W +: SYM_W];
            beat_colp    = beat_colp ^ bus.IN_SOURCE[s*SYM_W +: SYM_W];
        end
        data_m = data_q;
        rowp_m = rowp_q;
        colp_m = colp_q ^ beat_colp;
        last_m = last_q;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CW'(b)) begin
                data_m[(BEATS-1-b)*IN_W +: IN_W]                   = bus.IN_SOURCE;
                rowp_m[(BEATS-1-b)*SYMS_PER_BEAT +: SYMS_PER_BEAT] = beat_rowp;
                last_m[b]                                          = bus.SAMPLE_LAST;
            end
        end
    end

    always_comb begin
        data_d      = data_q;
        rowp_d      = rowp_q;
        colp_d      = colp_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        held_d      = held_q;
        out_valid_d = out_valid_q;
        out_coded_d = out_coded_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (held_q) begin
            if (out_fire) begin
                out_valid_d = 1'b1;
                out_coded_d = {data_q, rowp_q ^ {N{ODD}}, colp_q ^ {SYM_W{ODD}}};
                out_last_d  = last_q;
                out_user_d  = cnt_q;
                data_d      = '0;
                rowp_d      = '0;
                colp_d      = '0;
                cnt_d       = '0;
                last_d      = '0;
                held_d      = 1'b0;
            end
        end else if (accept) begin
            if (complete && out_free) begin
                out_valid_d = 1'b1;
                out_coded_d = {data_m, rowp_m ^ {N{ODD}}, colp_m ^ {SYM_W{ODD}}};
                out_last_d  = last_m;
                out_user_d  = cnt_q + CW'(1);
                data_d      = '0;
                rowp_d      = '0;
                colp_d      = '0;
                cnt_d       = '0;
                last_d      = '0;
            end else begin
                // Held blocks keep cnt = real beat count so it becomes OUT_USER on transfer.
                data_d = data_m;
                rowp_d = rowp_m;
                colp_d = colp_m;
                last_d = last_m;
                cnt_d  = cnt_q + CW'(1);
                held_d = complete;
            end
        end

        if (bus.FLUSH) begin
            data_d      = '0;
            rowp_d      = '0;
            colp_d      = '0;
            cnt_d       = '0;
            last_d      = '0;
            held_d      = 1'b0;
            out_valid_d = 1'b0;
            out_coded_d = '0;
            out_last_d  = '0;
            out_user_d  = '0;
        end

        ready_d = ~held_d;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            data_q      <= '0;
            rowp_q      <= '0;
            colp_q      <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            held_q      <= 1'b0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_coded_q <= '0;
            out_last_q  <= '0;
            out_user_q  <= '0;
        end else begin
            data_q      <= data_d;
            rowp_q      <= rowp_d;
            colp_q      <= colp_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            held_q      <= held_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            out_coded_q <= out_coded_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
        end
    end

    assign bus.READY     = ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_CODED = out_coded_q;
    assign bus.OUT_LAST  = out_last_q;
    assign bus.OUT_USER  = out_user_q;
endmodule
